// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back / write-allocate data cache controller.
// Hits complete in the same cycle; misses stall the pipeline through WRITEBACK/ALLOCATE.
module dcache_ctrl #(
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cpu_req_i,
    input  logic                          cpu_we_i,
    input  logic [31:0]                   cpu_addr_i,
    input  logic [31:0]                   cpu_wdata_i,
    output logic [31:0]                   cpu_rdata_o,
    output logic                          cpu_stall_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [31:0]                   mem_addr_o,
    output logic [32*WORDS_PER_LINE-1:0]  mem_wdata_o,
    input  logic [32*WORDS_PER_LINE-1:0]  mem_rdata_i,
    input  logic                          mem_ack_i
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned WRD_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned OFF_W = WRD_W + 2;
    localparam int unsigned TAG_W = 32 - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t state_q;

    logic [LINES-1:0]                     valid_q;
    logic [LINES-1:0]                     dirty_q;
    logic [TAG_W-1:0]                     tag_q  [LINES];
    logic [WORDS_PER_LINE-1:0][31:0]      data_q [LINES];

    logic [IDX_W-1:0]                     miss_idx_q;
    logic [TAG_W-1:0]                     miss_tag_q;

    logic [IDX_W-1:0]                     req_idx;
    logic [TAG_W-1:0]                     req_tag;
    logic [WRD_W-1:0]                     req_word;
    logic                                 hit;
    logic                                 unused_addr_bits;

    assign req_idx  = cpu_addr_i[OFF_W +: IDX_W];
    assign req_tag  = cpu_addr_i[31 -: TAG_W];
    assign req_word = cpu_addr_i[2 +: WRD_W];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign hit = (state_q == IDLE) && cpu_req_i && valid_q[req_idx]
                 && (tag_q[req_idx] == req_tag);

    // Gated with rst_i so both CPU outputs read 0 while reset is held, independent of the clock.
    always_comb begin
        cpu_stall_o = 1'b0;
        cpu_rdata_o = '0;
        if (rst_i) begin
            cpu_stall_o = (state_q != IDLE) || (cpu_req_i && !hit);
            if (hit && !cpu_we_i)
                cpu_rdata_o = data_q[req_idx][req_word];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            miss_idx_q  <= '0;
            miss_tag_q  <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req_i && !hit) begin
                        miss_idx_q <= req_idx;
                        miss_tag_q <= req_tag;
                        mem_req_o  <= 1'b1;
                        if (valid_q[req_idx] && dirty_q[req_idx]) begin
                            state_q     <= WRITEBACK;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= {tag_q[req_idx], req_idx, {OFF_W{1'b0}}};
                            mem_wdata_o <= data_q[req_idx];
                        end else begin
                            state_q     <= ALLOCATE;
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= {req_tag, req_idx, {OFF_W{1'b0}}};
                            mem_wdata_o <= '0;
                        end
                    end else if (hit && cpu_we_i) begin
                        dirty_q[req_idx] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    // Miss address is taken from the captured registers: the CPU may drop or change its request.
                    if (mem_ack_i) begin
                        state_q     <= ALLOCATE;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
                        mem_wdata_o <= '0;
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        state_q             <= IDLE;
                        valid_q[miss_idx_q] <= 1'b1;
                        dirty_q[miss_idx_q] <= 1'b0;
                        mem_req_o           <= 1'b0;
                        mem_we_o            <= 1'b0;
                        mem_addr_o          <= '0;
                        mem_wdata_o         <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; valid_q alone qualifies their contents.
    always_ff @(posedge clk_i) begin
        if (hit && cpu_we_i)
            data_q[req_idx][req_word] <= cpu_wdata_i;
        if (state_q == ALLOCATE && mem_ack_i) begin
            data_q[miss_idx_q] <= mem_rdata_i;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 16, number of direct-mapped lines (power of two).
REQ-002 SHALL have parameter WORDS_PER_LINE, default 4, 32-bit words per line (line = 128 bits).
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cpu_req_i  input  1  MEM-stage access request (MemRead or MemWrite).
REQ-006 SHALL have port cpu_we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port cpu_addr_i  input  32  byte address: [3:2] word, [7:4] index, [31:8] tag.
REQ-008 SHALL have port cpu_wdata_i  input  32  store data.
REQ-009 SHALL have port cpu_rdata_o  output  32  load data.
REQ-010 SHALL have port cpu_stall_o  output  1  freezes PC and all pipeline registers while high.
REQ-011 SHALL have port mem_req_o  output  1  backing-memory request.
REQ-012 SHALL have port mem_we_o  output  1  1 = line write-back, 0 = line fetch.
REQ-013 SHALL have port mem_addr_o  output  32  line-aligned address, bits [3:0] = 0.
REQ-014 SHALL have port mem_wdata_o  output  128  victim line, word 0 in bits [31:0].
REQ-015 SHALL have port mem_rdata_i  input  128  fetched line, valid only with mem_ack_i.
REQ-016 SHALL have port mem_ack_i  input  1  single-cycle completion pulse.

Function
REQ-017 SHALL hold per line: valid, dirty, 24-bit tag, 128-bit data; write-back, write-allocate policy.
REQ-018 SHALL implement FSM states IDLE, WRITEBACK, ALLOCATE.
REQ-019 SHALL in IDLE declare a hit when cpu_req_i=1, line valid and tag match.
REQ-020 SHALL on a load hit drive the addressed word on cpu_rdata_o combinationally in the same cycle, with cpu_stall_o=0.
REQ-021 SHALL on a store hit write cpu_wdata_i into the addressed word and set dirty at the rising edge, with cpu_stall_o=0.
REQ-022 SHALL on a miss in IDLE raise cpu_stall_o combinationally and go to WRITEBACK if the victim is valid and dirty, else to ALLOCATE.
REQ-023 SHALL in WRITEBACK drive mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 4'b0}, mem_wdata_o=victim line; on mem_ack_i go to ALLOCATE.
REQ-024 SHALL in ALLOCATE drive mem_req_o=1, mem_we_o=0, mem_addr_o={request tag, index, 4'b0}; on mem_ack_i write mem_rdata_i, set valid=1, dirty=0 and the new tag, then go to IDLE.
REQ-025 SHALL keep cpu_stall_o=1 in WRITEBACK and ALLOCATE; the retried access hits in IDLE the cycle after the ack.
REQ-026 SHALL hold mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stable until mem_ack_i, for any ack latency.
REQ-027 SHALL ignore mem_ack_i when mem_req_o=0.
REQ-028 SHALL, if cpu_req_i falls during a miss, finish the outstanding transaction and fill the line, then return to IDLE.
REQ-029 SHALL drive cpu_rdata_o=0 when cpu_req_i=0, on stores and while stalled.
REQ-030 SHALL drive cpu_stall_o=0, mem_req_o=0 and mem_we_o=0 when cpu_req_i=0 in IDLE.

Reset
REQ-031 SHALL on rst_i=0 immediately force state to IDLE, clear every valid and dirty bit, and drive all outputs to 0 regardless of the clock.
REQ-032 SHALL on reset in mid-transaction abandon it; mem_req_o falls asynchronously and a later ack is ignored.
REQ-033 SHALL need no reset on tag or data arrays.

Verification
REQ-034 Cold load miss: after reset, load 0x14; mem_addr_o=0x10, mem_we_o=0; ack with {0x33,0x22,0x11,0x00} -> next cycle cpu_stall_o=0, cpu_rdata_o=0x11.
REQ-035 Store hit: store 0xDEADBEEF to 0x14 -> cpu_stall_o=0; load 0x14 the next cycle -> 0xDEADBEEF without a memory request.
REQ-036 Dirty conflict: then load 0x114 -> WRITEBACK with mem_addr_o=0x10, mem_wdata_o={0x33,0x22,0xDEADBEEF,0x00}; after ack -> ALLOCATE with mem_addr_o=0x110.
REQ-037 Slow memory: ack delayed 5 cycles -> cpu_stall_o, mem_req_o, mem_addr_o and mem_wdata_o constant for all 5 cycles.
REQ-038 Reset during ALLOCATE: rst_i low -> mem_req_o=0 at once; after release, load 0x14 misses again.
REQ-039 Idle: cpu_req_i=0 with a stray mem_ack_i -> no state change, all outputs 0.
